// File: rtl/stream_coordinate_tracker.sv
// Receive-side raster tracker: tags each accepted beat with signed (x, y), checks line/frame framing
// and forwards tagged beats through a 2-entry skid buffer. Optional macro: STREAM_COORD_TRACKER_ERR_COUNT_EN.
module stream_coordinate_tracker #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 24,
    parameter int X_SIZE      = 2048,
    parameter int Y_SIZE      = 2048
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic                         in_eol,
    input  logic [PIXEL_WIDTH-1:0]       in_pixel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIXEL_WIDTH-1:0]       out_pixel,
    output logic signed [DATA_WIDTH-1:0] out_x,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic                         out_sof,
    output logic                         out_eol,
    output logic                         frame_done,
    output logic                         err_short_line,
    output logic                         err_long_line,
    output logic                         err_early_sof,
    output logic                         err_no_sof,
    output logic [15:0]                  err_count
);
    localparam logic signed [DATA_WIDTH-1:0] X_MIN = DATA_WIDTH'(-(X_SIZE / 2));
    localparam logic signed [DATA_WIDTH-1:0] X_MAX = DATA_WIDTH'(X_SIZE / 2 - 1);
    localparam logic signed [DATA_WIDTH-1:0] Y_MAX = DATA_WIDTH'(Y_SIZE / 2);
    localparam logic signed [DATA_WIDTH-1:0] Y_MIN = DATA_WIDTH'(1 - Y_SIZE / 2);
    localparam logic signed [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

    state_t                         state, state_nx;
    logic signed [DATA_WIDTH-1:0]   cur_x, cur_y, cur_x_nx, cur_y_nx;
    logic signed [DATA_WIDTH-1:0]   tag_x, tag_y;
    logic                           tag_sof, tag_eol;
    logic                           accept, fwd, push, pop;
    logic                           p_short, p_long, p_early, p_nosof, p_done;
    logic [1:0]                     count, count_nx;
    logic [PIXEL_WIDTH-1:0]         slot_pixel;
    logic signed [DATA_WIDTH-1:0]   slot_x, slot_y;
    logic                           slot_sof, slot_eol;

    assign accept = in_valid && in_ready;

    // cur_x/cur_y hold the coordinate the next accepted beat will carry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cur_x          <= X_MAX;
            cur_y          <= Y_MIN;
            frame_done     <= 1'b0;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_early_sof  <= 1'b0;
            err_no_sof     <= 1'b0;
        end else begin
            state          <= state_nx;
            cur_x          <= cur_x_nx;
            cur_y          <= cur_y_nx;
            frame_done     <= accept && p_done;
            err_short_line <= accept && p_short;
            err_long_line  <= accept && p_long;
            err_early_sof  <= accept && p_early;
            err_no_sof     <= accept && p_nosof;
        end
    end

    always_comb begin
        state_nx = state;
        cur_x_nx = cur_x;
        cur_y_nx = cur_y;
        if (accept) begin
            if (in_sof) begin
                state_nx = ACTIVE;
                cur_x_nx = X_MIN + ONE;
                cur_y_nx = Y_MAX;
            end else if (state == ACTIVE && !in_eol && cur_x != X_MAX) begin
                cur_x_nx = cur_x + ONE;
            end else if (state == ACTIVE && !in_eol) begin
                state_nx = DISCARD;
            end else if (state != IDLE && in_eol) begin
                if (cur_y == Y_MIN) begin
                    state_nx = IDLE;
                    cur_x_nx = X_MAX;
                    cur_y_nx = Y_MIN;
                end else begin
                    state_nx = ACTIVE;
                    cur_x_nx = X_MIN;
                    cur_y_nx = cur_y - ONE;
                end
            end
        end
    end

    always_comb begin
        fwd     = 1'b0;
        tag_x   = cur_x;
        tag_y   = cur_y;
        p_short = 1'b0;
        p_long  = 1'b0;
        p_early = 1'b0;
        p_nosof = 1'b0;
        p_done  = 1'b0;
        if (in_sof) begin
            fwd     = 1'b1;
            tag_x   = X_MIN;
            tag_y   = Y_MAX;
            p_early = (state != IDLE);
        end else begin
            case (state)
                IDLE:   p_nosof = 1'b1;
                ACTIVE: begin
                    fwd     = 1'b1;
                    p_short = in_eol && (cur_x < X_MAX);
                    p_long  = !in_eol && (cur_x == X_MAX);
                    p_done  = in_eol && (cur_x == X_MAX) && (cur_y == Y_MIN);
                end
                default: fwd = 1'b0;
            endcase
        end
        tag_sof = (tag_x == X_MIN) && (tag_y == Y_MAX);
        tag_eol = (tag_x == X_MAX);
    end

    // Skid buffer: head entry drives out_* directly, slot holds the overflow beat
    assign push      = accept && fwd;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign count_nx  = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count     <= 2'd0;
            in_ready  <= 1'b0;
            out_pixel <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            count    <= count_nx;
            in_ready <= (count_nx != 2'd2);
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                out_pixel <= in_pixel;
                out_x     <= tag_x;
                out_y     <= tag_y;
                out_sof   <= tag_sof;
                out_eol   <= tag_eol;
            end else if (pop && count == 2'd2) begin
                out_pixel <= slot_pixel;
                out_x     <= slot_x;
                out_y     <= slot_y;
                out_sof   <= slot_sof;
                out_eol   <= slot_eol;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && count == 2'd1 && !pop) begin
            slot_pixel <= in_pixel;
            slot_x     <= tag_x;
            slot_y     <= tag_y;
            slot_sof   <= tag_sof;
            slot_eol   <= tag_eol;
        end
    end

`ifdef STREAM_COORD_TRACKER_ERR_COUNT_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [2:0] err_inc;
    assign err_inc = {2'b0, err_short_line} + {2'b0, err_long_line}
                   + {2'b0, err_early_sof} + {2'b0, err_no_sof};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_count <= 16'd0;
        else         err_count <= sat_add16(err_count, err_inc);
    end
`else
    assign err_count = 16'd0;
`endif

endmodule
